// File: rtl/external_interrupt_controller_if.sv
// ----------------------------------------------------------------------------
// external_interrupt_controller_if
//   Bundles the core's I/O bus and the core interrupt handshake for the
//   external interrupt controller.
//   master : the core side (drives strobes, address, write data, Ack)
//   slave  : the controller side (drives read data, Req, Id)
//   Signals:
//     IO_EnR, IO_EnW   read / write strobes (MA stage)
//     IO_Address[29:0] word address
//     IO_DataW[31:0]   write data
//     IO_DataR[31:0]   registered read data (WB stage)
//     EIC_I_Req        interrupt request to the core
//     EIC_I_Id         class of the requested source (1 = high class)
//     EIC_I_Ack        core accepts the request
// ----------------------------------------------------------------------------
interface external_interrupt_controller_if;
  logic        IO_EnR;
  logic        IO_EnW;
  logic [29:0] IO_Address;
  logic [31:0] IO_DataW;
  logic [31:0] IO_DataR;
  logic        EIC_I_Req;
  logic        EIC_I_Id;
  logic        EIC_I_Ack;

  modport master (
    output IO_EnR, IO_EnW, IO_Address, IO_DataW, EIC_I_Ack,
    input  IO_DataR, EIC_I_Req, EIC_I_Id
  );

  modport slave (
    input  IO_EnR, IO_EnW, IO_Address, IO_DataW, EIC_I_Ack,
    output IO_DataR, EIC_I_Req, EIC_I_Id
  );
endinterface

// File: rtl/external_interrupt_controller.sv
// ----------------------------------------------------------------------------
// external_interrupt_controller
//   Synchronises NUM_SRC asynchronous interrupt lines, latches them as pending
//   (edge or level per source), picks one eligible source (high class first,
//   then lowest index), requests the core and keeps the granted source in
//   service until software writes EOI.
//   Ports:
//     Sys_Clock  single clock, all state on the rising edge
//     Sys_Reset  synchronous active-high reset
//     Src_In     raw device interrupt lines (asynchronous, active-high)
//     bus        slave side of the I/O bus + interrupt handshake
//   Register window (word offsets from BASE_ADDR):
//     0 PEND (R/W1C)  1 MASK  2 LVL  3 TRIG  4 CAUSE (R)  5 EOI (W)  6,7 zero
// ----------------------------------------------------------------------------
module external_interrupt_controller #(
  parameter int          NUM_SRC   = 8,
  parameter logic [29:0] BASE_ADDR = 30'h3FF0
) (
  input  logic                 Sys_Clock,
  input  logic                 Sys_Reset,
  input  logic [NUM_SRC-1:0]   Src_In,
  external_interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_SRC-1:0] pend_q, pend_d, mask_q, lvl_q, trig_q;
  logic [NUM_SRC-1:0] edge_det, w1c, gclr, elig, elig_hi;
  logic [3:0]         cause_idx_q, sel_idx;
  logic               cause_id_q, cause_srv_q, sel_id;
  logic [31:0]        data_r_q, rd_val;
  logic               hit, wr_en, ack_in_req, eoi_in_serv;
  logic [2:0]         off;
  logic               unused_dataw;

  assign hit         = (bus.IO_Address[29:3] == BASE_ADDR[29:3]);
  assign off         = bus.IO_Address[2:0];
  assign wr_en       = hit & bus.IO_EnW;
  assign ack_in_req  = (state_q == REQ) & bus.EIC_I_Ack;
  assign eoi_in_serv = (state_q == SERV) & wr_en & (off == 3'd5);
  assign edge_det    = sync2_q & ~sync3_q;
  assign w1c         = (wr_en && off == 3'd0) ? bus.IO_DataW[NUM_SRC-1:0] : '0;
  assign elig        = pend_q & mask_q;
  assign elig_hi     = elig & lvl_q;
  // Bits above NUM_SRC are don't-care on writes.
  assign unused_dataw = ^bus.IO_DataW[31:NUM_SRC];

  // Per-source pending update. Edge mode: a new edge wins over any clear in
  // the same cycle. Level mode: pending simply follows the synchronised line.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
    assign gclr[gi]   = ack_in_req & (cause_idx_q == 4'(gi)) & trig_q[gi];
    assign pend_d[gi] = trig_q[gi]
                      ? (edge_det[gi] | (pend_q[gi] & ~w1c[gi] & ~gclr[gi]))
                      : sync2_q[gi];
  end

  // Priority select: lowest index among high-class eligible sources, else
  // lowest index among all eligible sources. Loops run high-to-low so the
  // last assignment is the lowest index.
  always_comb begin
    sel_idx = '0;
    sel_id  = 1'b0;
    if (|elig_hi) begin
      sel_id = 1'b1;
      for (int i = NUM_SRC - 1; i >= 0; i--)
        if (elig_hi[i]) sel_idx = 4'(i);
    end else begin
      for (int i = NUM_SRC - 1; i >= 0; i--)
        if (elig[i]) sel_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|elig) state_d = REQ;
      REQ:     if (bus.EIC_I_Ack) state_d = SERV;
      SERV:    if (eoi_in_serv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (off)
      3'd0:    rd_val[NUM_SRC-1:0] = pend_q;
      3'd1:    rd_val[NUM_SRC-1:0] = mask_q;
      3'd2:    rd_val[NUM_SRC-1:0] = lvl_q;
      3'd3:    rd_val[NUM_SRC-1:0] = trig_q;
      3'd4:    rd_val = {cause_srv_q, 22'b0, cause_id_q, 4'b0, cause_idx_q};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      lvl_q       <= '0;
      trig_q      <= '0;
      cause_idx_q <= '0;
      cause_id_q  <= 1'b0;
      cause_srv_q <= 1'b0;
      data_r_q    <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= Src_In;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      pend_q  <= pend_d;
      if (wr_en && off == 3'd1) mask_q <= bus.IO_DataW[NUM_SRC-1:0];
      if (wr_en && off == 3'd2) lvl_q  <= bus.IO_DataW[NUM_SRC-1:0];
      if (wr_en && off == 3'd3) trig_q <= bus.IO_DataW[NUM_SRC-1:0];
      // CAUSE index/class is captured once when leaving IDLE, so a later
      // mask or clear of the source cannot change a committed request.
      if (state_q == IDLE && (|elig)) begin
        cause_idx_q <= sel_idx;
        cause_id_q  <= sel_id;
      end
      if (ack_in_req)  cause_srv_q <= 1'b1;
      if (eoi_in_serv) cause_srv_q <= 1'b0;
      // rd_val comes from the current registers, so a same-cycle write is
      // not visible in this read.
      if (hit && bus.IO_EnR) data_r_q <= rd_val;
    end
  end

  assign bus.IO_DataR  = data_r_q;
  assign bus.EIC_I_Req = (state_q == REQ);
  assign bus.EIC_I_Id  = (state_q == REQ) & cause_id_q;

endmodule

// File: tb/tb_external_interrupt_controller.sv
// ----------------------------------------------------------------------------
// tb_external_interrupt_controller
//   Directed scoreboard bench. Stimulus pushes expected read data and
//   expected request classes into queues; monitors pop and compare when the
//   DUT presents read data (cycle after a hit read) or raises Req.
// ----------------------------------------------------------------------------
module tb_external_interrupt_controller;
  localparam logic [29:0] BASE = 30'h3FF0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] src = 8'h00;

  external_interrupt_controller_if bus();

  external_interrupt_controller #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
    .Sys_Clock (clk),
    .Sys_Reset (rst),
    .Src_In    (src),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic        req_exp_q[$];
  logic        rd_issue = 1'b0;
  logic        req_prev = 1'b0;
  logic [31:0] mon_exp;
  string       mon_name;
  logic        mon_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Read-data monitor: a hit read loads IO_DataR at the edge, so compare on
  // the following falling edge.
  always @(posedge clk)
    rd_issue <= bus.IO_EnR && !rst && (bus.IO_Address[29:3] == BASE[29:3]);

  always @(negedge clk) begin
    if (rd_issue) begin
      if (rd_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%08h expected no read", bus.IO_DataR);
      end else begin
        mon_exp  = rd_exp_q.pop_front();
        mon_name = rd_name_q.pop_front();
        check(mon_name, bus.IO_DataR, mon_exp);
      end
    end
    if (bus.EIC_I_Req && !req_prev) begin
      if (req_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got Req with Id=%0d expected no Req", bus.EIC_I_Id);
      end else begin
        mon_id = req_exp_q.pop_front();
        check("req_id", {31'b0, bus.EIC_I_Id}, {31'b0, mon_id});
      end
    end
    req_prev <= bus.EIC_I_Req;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    bus.IO_Address = {BASE[29:3], off};
    bus.IO_DataW   = d;
    bus.IO_EnW     = 1'b1;
    tick();
    bus.IO_EnW     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    bus.IO_Address = {BASE[29:3], off};
    bus.IO_EnR     = 1'b1;
    tick();
    bus.IO_EnR     = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] off, input logic [31:0] d,
                      input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    bus.IO_Address = {BASE[29:3], off};
    bus.IO_DataW   = d;
    bus.IO_EnR     = 1'b1;
    bus.IO_EnW     = 1'b1;
    tick();
    bus.IO_EnR     = 1'b0;
    bus.IO_EnW     = 1'b0;
  endtask

  task automatic ack();
    bus.EIC_I_Ack = 1'b1;
    tick();
    bus.EIC_I_Ack = 1'b0;
  endtask

  task automatic wait_req(input int max, input string name);
    int n = 0;
    while (!bus.EIC_I_Req && n < max) begin
      tick();
      n++;
    end
    check(name, {31'b0, bus.EIC_I_Req}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [29:0] miss_addr;
    bus.IO_EnR     = 1'b0;
    bus.IO_EnW     = 1'b0;
    bus.IO_Address = '0;
    bus.IO_DataW   = '0;
    bus.EIC_I_Ack  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    check("rst_req",   {31'b0, bus.EIC_I_Req}, 32'd0);
    check("rst_id",    {31'b0, bus.EIC_I_Id},  32'd0);
    check("rst_datar", bus.IO_DataR,           32'd0);

    // 1: edge source 0, low class
    wr(3'd1, 32'h01);
    wr(3'd3, 32'h01);
    req_exp_q.push_back(1'b0);
    src = 8'h01;
    tick(2);
    src = 8'h00;
    wait_req(6, "t1_req");
    rd(3'd0, 32'h01, "t1_pend");
    rd(3'd4, 32'h0,  "t1_cause");

    // 2: Ack clears edge pending and marks in service; EOI ends service
    ack();
    check("t2_req_drop", {31'b0, bus.EIC_I_Req}, 32'd0);
    rd(3'd0, 32'h0,         "t2_pend");
    rd(3'd4, 32'h8000_0000, "t2_cause");
    wr(3'd5, 32'h0);
    rd(3'd4, 32'h0,         "t2_cause_eoi");

    // 3: high class wins over lower index; the other source follows
    wr(3'd1, 32'hFF);
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h40);
    req_exp_q.push_back(1'b1);
    req_exp_q.push_back(1'b0);
    src = 8'h44;
    tick(2);
    src = 8'h00;
    wait_req(6, "t3_req1");
    rd(3'd4, 32'h0000_0106, "t3_cause1");
    ack();
    rd(3'd4, 32'h8000_0106, "t3_cause1_srv");
    rd(3'd0, 32'h04,        "t3_pend_after_ack");
    wr(3'd5, 32'h0);
    wait_req(4, "t3_req2");
    rd(3'd4, 32'h0000_0002, "t3_cause2");
    ack();
    wr(3'd5, 32'h0);
    rd(3'd0, 32'h0, "t3_pend_final");

    // 4: level source 3 ignores W1C and follows the line
    wr(3'd1, 32'h00);
    wr(3'd3, 32'hF7);
    src = 8'h08;
    tick(4);
    rd(3'd0, 32'h08, "t4_pend_level");
    wr(3'd0, 32'h08);
    rd(3'd0, 32'h08, "t4_w1c_ignored");
    src = 8'h00;
    tick(3);
    rd(3'd0, 32'h00, "t4_pend_drop");

    // 5: masked source latches pending; unmasking raises Req next cycle
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h00);
    src = 8'h02;
    tick(2);
    src = 8'h00;
    tick(3);
    check("t5_req_masked", {31'b0, bus.EIC_I_Req}, 32'd0);
    rd(3'd0, 32'h02, "t5_pend_masked");
    req_exp_q.push_back(1'b0);
    wr(3'd1, 32'h02);
    check("t5_req_not_yet", {31'b0, bus.EIC_I_Req}, 32'd0);
    tick();
    check("t5_req_after_mask", {31'b0, bus.EIC_I_Req}, 32'd1);
    rd(3'd4, 32'h0000_0001, "t5_cause");

    // 6: reset in REQ, then a stale Ack
    rst = 1'b1;
    tick();
    check("t6_req_rst",   {31'b0, bus.EIC_I_Req}, 32'd0);
    check("t6_datar_rst", bus.IO_DataR,           32'd0);
    rst = 1'b0;
    ack();
    check("t6_stale_ack", {31'b0, bus.EIC_I_Req}, 32'd0);
    for (int o = 0; o < 8; o++)
      rd(3'(o), 32'h0, $sformatf("t6_reg%0d", o));

    // 7: read+write same cycle, unimplemented bits, reserved offset, miss
    rdwr(3'd1, 32'hFFFF_FFFF, 32'h0, "t7_rdwr_prewrite");
    rd(3'd1, 32'hFF, "t7_mask_width");
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'h0,  "t7_reg6");
    rd(3'd1, 32'hFF, "t7_mask_again");
    wr(3'd1, 32'h00);
    miss_addr      = {BASE[29:3] + 27'd1, 3'd6};
    bus.IO_Address = miss_addr;
    bus.IO_EnR     = 1'b1;
    tick();
    bus.IO_EnR     = 1'b0;
    tick();
    check("t7_miss_hold", bus.IO_DataR, 32'hFF);

    tick(3);
    check("rd_queue_empty",  rd_exp_q.size(),  32'd0);
    check("req_queue_empty", req_exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
